vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_pkg.sv | 21 ++
 rtl/vram_arbiter.sv | 141 ++++++++++++++
 tb/tb_vram_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// Shared constants and FSM encoding for the framebuffer arbiter.
// Build option: VRAM_CPU_READ_EN enables real CPU reads through the RAM.
package vram_pkg;

    localparam int VRAM_AW = 16;
    localparam int VRAM_DW = 8;

    // Impossible visible coordinate, so the first visible pixel always fetches
    localparam logic [VRAM_AW-1:0] LAST_RST = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISP_CAP = 2'd1,
        CPU_WR   = 2'd2
`ifdef VRAM_CPU_READ_EN
        ,
        CPU_CAP  = 2'd3
`endif
    } state_e;

endpackage

// File: rtl/vram_arbiter.sv
// Single-port framebuffer arbiter: display fetches win, CPU gets the rest.
// Build option: VRAM_CPU_READ_EN (undefined = reads ack with zero data).
module vram_arbiter
    import vram_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               disp_vis,
    input  logic [7:0]         disp_h,
    input  logic [7:0]         disp_v,
    output logic [VRAM_DW-1:0] disp_pixel,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [VRAM_AW-1:0] cpu_addr,
    input  logic [VRAM_DW-1:0] cpu_wdata,
    output logic [VRAM_DW-1:0] cpu_rdata,
    output logic               cpu_ack,
    output logic [VRAM_AW-1:0] ram_addr,
    output logic               ram_we,
    output logic [VRAM_DW-1:0] ram_wdata,
    input  logic [VRAM_DW-1:0] ram_rdata
);

    state_e             state_q, state_d;
    logic [VRAM_AW-1:0] last_q, last_d;
    logic               pend_q, pend_d;
    logic [VRAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic               ram_we_q, ram_we_d;
    logic [VRAM_DW-1:0] ram_wdata_q, ram_wdata_d;
    logic               cpu_ack_q, cpu_ack_d;
    logic [VRAM_DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [VRAM_DW-1:0] disp_pixel_q, disp_pixel_d;

    logic [VRAM_AW-1:0] coord;
    logic               slot;
    logic               cpu_go;

    assign coord  = {disp_v, disp_h};
    assign slot   = disp_vis && (pend_q || (coord != last_q));
    // The ack cycle itself never starts a new op, so acks cannot abut
    assign cpu_go = cpu_req && !cpu_ack_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_q       <= LAST_RST;
            pend_q       <= 1'b0;
            ram_addr_q   <= '0;
            ram_we_q     <= 1'b0;
            ram_wdata_q  <= '0;
            cpu_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            disp_pixel_q <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            pend_q       <= pend_d;
            ram_addr_q   <= ram_addr_d;
            ram_we_q     <= ram_we_d;
            ram_wdata_q  <= ram_wdata_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            disp_pixel_q <= disp_pixel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (slot) begin
                    state_d = DISP_CAP;
                end else if (cpu_go && cpu_we) begin
                    state_d = CPU_WR;
                end
`ifdef VRAM_CPU_READ_EN
                else if (cpu_go) begin
                    state_d = CPU_CAP;
                end
`endif
            end
            DISP_CAP: state_d = IDLE;
            CPU_WR:   state_d = IDLE;
`ifdef VRAM_CPU_READ_EN
            CPU_CAP:  state_d = IDLE;
`endif
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        ram_addr_d   = ram_addr_q;
        ram_we_d     = 1'b0;
        ram_wdata_d  = ram_wdata_q;
        cpu_ack_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        disp_pixel_d = disp_pixel_q;
        last_d       = last_q;
        pend_d       = slot;
        unique case (state_q)
            IDLE: begin
                if (slot) begin
                    ram_addr_d = coord;
                    last_d     = coord;
                    pend_d     = 1'b0;
                end else if (cpu_go && cpu_we) begin
                    ram_addr_d  = cpu_addr;
                    ram_wdata_d = cpu_wdata;
                    ram_we_d    = 1'b1;
                end else if (cpu_go) begin
`ifdef VRAM_CPU_READ_EN
                    ram_addr_d = cpu_addr;
`else
                    cpu_rdata_d = '0;
                    cpu_ack_d   = 1'b1;
`endif
                end
            end
            DISP_CAP: disp_pixel_d = ram_rdata;
            CPU_WR:   cpu_ack_d = 1'b1;
`ifdef VRAM_CPU_READ_EN
            CPU_CAP: begin
                cpu_rdata_d = ram_rdata;
                cpu_ack_d   = 1'b1;
            end
`endif
            default: ;
        endcase
        if (!disp_vis) begin
            disp_pixel_d = '0;
        end
    end

    assign disp_pixel = disp_pixel_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_ack    = cpu_ack_q;
    assign ram_addr   = ram_addr_q;
    assign ram_we     = ram_we_q;
    assign ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: random CPU traffic over a scaled frame.
// Expectations come from a shadow memory model and the arbitration rules.
`timescale 1ns/1ps
module tb_vram_arbiter;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } cpu_exp_t;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_exp_t;

    typedef struct {
        int         due;
        logic [7:0] val;
    } pix_exp_t;

    logic        clk;
    logic        rst_n;
    logic        disp_vis;
    logic [7:0]  disp_h;
    logic [7:0]  disp_v;
    logic [7:0]  disp_pixel;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];

    cpu_exp_t cpu_q[$];
    wr_exp_t  wr_q[$];
    pix_exp_t pix_q[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int ack_vis = 0;
    int ack_blank = 0;
    logic prev_ack = 1'b0;
    logic prev_we = 1'b0;
    logic frame_done = 1'b0;

    vram_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .disp_vis   (disp_vis),
        .disp_h     (disp_h),
        .disp_v     (disp_v),
        .disp_pixel (disp_pixel),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ack    (cpu_ack),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ram_addr is already a register, so the array read lands in the next cycle
    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;
    assign ram_rdata = mem[ram_addr];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] read_model(input logic [15:0] a);
`ifdef VRAM_CPU_READ_EN
        return ref_mem[a];
`else
        return 8'h00;
`endif
    endfunction

    task automatic cpu_op(input logic we, input logic [15:0] a,
                          input logic [7:0] d);
        cpu_exp_t e;
        wr_exp_t  w;
        int n;
        e.we   = we;
        e.addr = a;
        e.data = we ? d : read_model(a);
        cpu_q.push_back(e);
        if (we) begin
            w.addr = a;
            w.data = d;
            wr_q.push_back(w);
            ref_mem[a] = d;
        end
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!cpu_ack && n < 50);
        chk("cpu_ack_timeout", 32'(cpu_ack), 1);
        cpu_req = 1'b0;
    endtask

    task automatic set_disp(input logic vis, input logic [7:0] v,
                            input logic [7:0] h);
        pix_exp_t p;
        disp_vis = vis;
        disp_v   = v;
        disp_h   = h;
        p.due    = cyc + 4;
        p.val    = vis ? ref_mem[{v, h}] : 8'h00;
        pix_q.push_back(p);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        cpu_exp_t e;
        wr_exp_t  w;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (cpu_ack) begin
                    chk("ack_back_to_back", 32'(prev_ack), 0);
                    if (disp_vis) ack_vis++;
                    else ack_blank++;
                    chk("ack_expected", 32'(cpu_q.size() != 0), 1);
                    if (cpu_q.size() != 0) begin
                        e = cpu_q.pop_front();
                        if (!e.we) chk("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
                    end
                end
                if (ram_we) begin
                    chk("ram_we_back_to_back", 32'(prev_we), 0);
                    chk("write_expected", 32'(wr_q.size() != 0), 1);
                    if (wr_q.size() != 0) begin
                        w = wr_q.pop_front();
                        chk("ram_addr_wr", 32'(ram_addr), 32'(w.addr));
                        chk("ram_wdata", 32'(ram_wdata), 32'(w.data));
                    end
                end
                if (pix_q.size() != 0 && pix_q[0].due <= cyc) begin
                    chk("disp_pixel", 32'(disp_pixel), 32'(pix_q[0].val));
                    void'(pix_q.pop_front());
                end
            end
            prev_ack = cpu_ack;
            prev_we  = ram_we;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        logic [15:0] prev_addr;
        logic [7:0]  d;
        for (int i = 0; i < 65536; i++) begin
            d = 8'($urandom);
            mem[i]     = d;
            ref_mem[i] = d;
        end
        rst_n = 1'b0;
        disp_vis = 1'b0;
        disp_h = 8'h00;
        disp_v = 8'h00;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = 16'h0000;
        cpu_wdata = 8'h00;
        tick(3);
        chk("rst_disp_pixel", 32'(disp_pixel), 0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
        chk("rst_cpu_ack", 32'(cpu_ack), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_ram_wdata", 32'(ram_wdata), 0);
        rst_n = 1'b1;
        tick(2);

        // write then display the same location
        cpu_op(1'b1, 16'h0102, 8'hE0);
        tick(2);
        set_disp(1'b1, 8'h01, 8'h02);
        tick(4);

        // display slot and CPU write arrive together
        set_disp(1'b1, 8'h01, 8'h03);
        fork
            cpu_op(1'b1, 16'h8123, 8'h5A);
            begin
                @(posedge clk);
                @(negedge clk);
                chk("disp_first_addr", 32'(ram_addr), 32'h0103);
                chk("disp_first_we", 32'(ram_we), 0);
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                chk("cpu_second_we", 32'(ram_we), 1);
                chk("cpu_second_addr", 32'(ram_addr), 32'h8123);
            end
        join
        tick(3);
        set_disp(1'b1, 8'h01, 8'h02);
        tick(4);

        // CPU read during blanking
        set_disp(1'b0, 8'h01, 8'h02);
        tick(3);
        prev_addr = ram_addr;
        cpu_op(1'b0, 16'h0102, 8'h00);
`ifdef VRAM_CPU_READ_EN
        chk("read_ram_addr", 32'(ram_addr), 32'h0102);
`else
        chk("read_ram_addr", 32'(ram_addr), 32'(prev_addr));
`endif
        tick(3);

        // reset in the middle of a write
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 16'h0102;
        cpu_wdata = 8'h33;
        tick(1);
        chk("abort_we_before", 32'(ram_we), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_we_async", 32'(ram_we), 0);
        cpu_req = 1'b0;
        tick(2);
        chk("abort_no_ack", 32'(cpu_ack), 0);
        chk("abort_pixel", 32'(disp_pixel), 0);
        rst_n = 1'b1;
        set_disp(1'b1, 8'h01, 8'h02);
        tick(4);
        chk("abort_no_ack_after", 32'(cpu_ack), 0);

        // scaled frames: 24x8 visible of 32x10, 4 clocks per pixel
        fork
            begin
                for (int f = 0; f < 2; f++) begin
                    for (int v = 0; v < 10; v++) begin
                        for (int h = 0; h < 32; h++) begin
                            set_disp(v < 8 && h < 24, 8'(v), 8'(h));
                            tick(4);
                        end
                    end
                end
                frame_done = 1'b1;
            end
            begin
                while (!frame_done) begin
                    cpu_op($urandom_range(0, 2) != 0,
                           {1'b1, 7'($urandom), 8'($urandom)},
                           8'($urandom));
                    tick($urandom_range(0, 2));
                end
            end
        join
        tick(10);

        chk("cpu_q_drained", 32'(cpu_q.size()), 0);
        chk("wr_q_drained", 32'(wr_q.size()), 0);
        chk("pix_q_drained", 32'(pix_q.size()), 0);
        chk("acks_in_video", 32'(ack_vis > 0), 1);
        chk("acks_in_blank", 32'(ack_blank > 0), 1);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
